axis_pixel_point_op: RTL

Parametrised AXI4-Stream per-pixel point-operation engine for the image filter pipeline. It is the successor to the fixed 8-bit invert stage. It applies one of four runtime-selectable operations to every pixel lane of each beat: pass, invert, saturating brighten, or threshold. It supports full backpressure, packet (line) framing via tlast, and a mode/operand latched per packet.

---
 rtl/pixel_op_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 52 +++++
 rtl/axis_pixel_point_op.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pixel_op_pkg.sv
// Shared types for the AXI4-Stream per-pixel point-operation engine.
// Mode encoding and config-latch FSM states.
package pixel_op_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    INVERT  = 2'd1,
    ADD_SAT = 2'd2,
    THRESH  = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready skid buffer with a registered input ready.
// Ready drops only once both entries are occupied.
module axis_skid_buffer #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_nxt = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axis_pixel_point_op.sv
// AXI4-Stream point-operation engine: pass, invert, saturating add or
// threshold per pixel lane, with mode/operand latched per packet.
module axis_pixel_point_op
  import pixel_op_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int PIXELS_PER_BEAT = 4
) (
  input  logic                                 axi_clk,
  input  logic                                 axi_reset,
  input  logic [1:0]                           cfg_mode,
  input  logic [PIXEL_WIDTH-1:0]               cfg_operand,
  input  logic                                 s_axis_valid,
  input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] s_axis_data,
  input  logic                                 s_axis_last,
  output logic                                 s_axis_ready,
  output logic                                 m_axis_valid,
  output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] m_axis_data,
  output logic                                 m_axis_last,
  input  logic                                 m_axis_ready,
  output logic                                 pkt_done
);

  localparam int PW      = PIXEL_WIDTH;
  localparam int DW      = PIXEL_WIDTH * PIXELS_PER_BEAT;
  localparam int SKID_W  = DW + 1 + 2 + PW;
  localparam int LAST_B  = DW;
  localparam int MODE_LO = DW + 1;
  localparam int OP_LO   = DW + 3;
  localparam logic [PW-1:0] PIX_MAX = '1;

  state_t        state;
  state_t        state_nxt;
  mode_t         lat_mode;
  mode_t         use_mode;
  logic [PW-1:0] lat_op;
  logic [PW-1:0] use_op;
  logic          s_fire;

  assign s_fire = s_axis_valid & s_axis_ready;

  always_comb begin
    state_nxt = state;
    use_mode  = lat_mode;
    use_op    = lat_op;
    unique case (state)
      IDLE: begin
        use_mode = mode_t'(cfg_mode);
        use_op   = cfg_operand;
      end
      IN_PKT: begin
      end
    endcase
    if (s_fire) state_nxt = s_axis_last ? IDLE : IN_PKT;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state    <= IDLE;
      lat_mode <= PASS;
      lat_op   <= '0;
    end else begin
      state <= state_nxt;
      if (s_fire) begin
        lat_mode <= use_mode;
        lat_op   <= use_op;
      end
    end
  end

  logic              sk_valid;
  logic              sk_ready;
  logic [SKID_W-1:0] sk_in;
  logic [SKID_W-1:0] sk_out;
  logic [DW-1:0]     sk_pix;
  logic              sk_last;
  mode_t             sk_mode;
  logic [PW-1:0]     sk_op;

  // Config travels with each beat so later stages never see cfg_* directly.
  assign sk_in = {use_op, use_mode, s_axis_last, s_axis_data};

  axis_skid_buffer #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk       (axi_clk),
    .rst       (axi_reset),
    .in_valid  (s_axis_valid),
    .in_data   (sk_in),
    .in_ready  (s_axis_ready),
    .out_valid (sk_valid),
    .out_data  (sk_out),
    .out_ready (sk_ready)
  );

  assign sk_pix  = sk_out[DW-1:0];
  assign sk_last = sk_out[LAST_B];
  assign sk_mode = mode_t'(sk_out[MODE_LO +: 2]);
  assign sk_op   = sk_out[OP_LO +: PW];

  logic [DW-1:0] alu_data;

  for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_lane
    logic [PW-1:0] p;
    logic [PW:0]   sum;
    logic [PW-1:0] res;

    assign p   = sk_pix[i*PW +: PW];
    assign sum = {1'b0, p} + {1'b0, sk_op};

    always_comb begin
      res = p;
      unique case (sk_mode)
        PASS:    res = p;
        INVERT:  res = PIX_MAX - p;
        ADD_SAT: res = sum[PW] ? PIX_MAX : sum[PW-1:0];
        THRESH:  res = (p >= sk_op) ? PIX_MAX : '0;
      endcase
    end

    assign alu_data[i*PW +: PW] = res;
  end

  logic pipe_en;

  assign pipe_en  = ~m_axis_valid | m_axis_ready;
  assign sk_ready = pipe_en;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      pkt_done     <= 1'b0;
    end else begin
      pkt_done <= m_axis_valid & m_axis_ready & m_axis_last;
      if (pipe_en) begin
        m_axis_valid <= sk_valid;
        if (sk_valid) begin
          m_axis_data <= alu_data;
          m_axis_last <= sk_last;
        end
      end
    end
  end

endmodule
